axi_ad9364_pat_mon: RTL
=======================

Name: axi_ad9364_pat_mon

Overview:
Receive-side pattern monitor for the AD9364 digital interface. It checks adc_valid/adc_data_i1/adc_data_q1 against the repeating 3-entry I/Q test sequence that the transmit-side generator drives into dac_data_i1/q1. The sequence is looped back through the AD9364 or a cable.
It locks onto the sequence, detects loss of sync, and counts matched and errored samples. Status outputs go to chipscope and a later up_* register bank. It sits in the clk domain next to axi_ad9364_dig_if.

Parameters:
IDATA1, 12'o3777, expected I for sequence entry 0
IDATA2, 12'o0000, expected I for entry 1
IDATA3, 12'o4000, expected I for entry 2
QDATA1, 12'o3737, expected Q for entry 0
QDATA2, 12'o1737, expected Q for entry 1
QDATA3, 12'o0000, expected Q for entry 2
LOCK_COUNT, 4, consecutive in-order matches required to lock (1..15)
MISS_LIMIT, 3, consecutive mismatches while locked that force loss of lock (1..15)
TIMEOUT, 64, clk cycles without adc_valid while locked that force loss of lock (2..65535)

Ports:
clk  input  1  interface clock from axi_ad9364_dig_if, rising edge
rstn  input  1  asynchronous active-low reset
mon_enable  input  1  1 = monitor runs; 0 = go to IDLE, counters hold
mon_clear  input  1  single-cycle pulse: zero err_count and match_count
adc_valid  input  1  sample qualifier from dig_if
adc_data_i1  input  12  received I sample
adc_data_q1  input  12  received Q sample
adc_status  input  1  dig_if interface-OK flag
mon_locked  output  1  1 while in LOCKED
mon_oos  output  1  sticky out-of-sync flag; cleared by mon_clear
mon_err  output  1  one-cycle pulse per mismatched sample while LOCKED
mon_state  output  2  current state encoding (debug)
err_count  output  32  saturating count of mismatched samples while LOCKED
match_count  output  32  saturating count of matched samples while LOCKED

Behaviour:
- Reset (async assert, sync release on clk): state IDLE, all outputs 0, internal index/run counters 0.
- Sample = clk edge with adc_valid=1 and adc_status=1. Samples with adc_status=0 are ignored.
- adc_status=0 while in SEARCH or LOCKED forces SEARCH on the next edge. If the state was LOCKED, mon_oos is set.
- Latency: a sample on edge k updates state, counters, mon_err and mon_locked on edge k+1 (one register stage).
- Match is exact 12-bit equality of both I and Q against the entry selected by exp_idx (0..2). exp_idx wraps 2 -> 0.
- States (mon_state): IDLE=2'd0, SEARCH=2'd1, LOCKED=2'd2; 2'd3 is unused and recovers to IDLE.
- IDLE: entered whenever mon_enable=0; this overrides all other transitions. Leaves to SEARCH when mon_enable=1.
- SEARCH, sample matching any entry j: set exp_idx=j+1 mod 3 and run=1.
- SEARCH, sample matching exp_idx: run+1, advance exp_idx.
- SEARCH, any other sample: run=0, restart from that sample. A sample that matches some entry but is out of order restarts the run at 1.
- SEARCH -> LOCKED when run reaches LOCK_COUNT. Counters are not touched in SEARCH.
- LOCKED, every sample: exp_idx advances whether or not the sample matched. This keeps alignment through a single bit error.
- LOCKED, match: match_count+1, miss=0.
- LOCKED, mismatch: err_count+1, mon_err pulse, miss+1.
- LOCKED -> SEARCH (mon_oos set) when miss reaches MISS_LIMIT, or when the idle-gap counter reaches TIMEOUT.
- Idle-gap counter: reset by each sample, incremented on each clk without one.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- mon_clear on the same edge as a counting event: clear wins; counter ends at 0 and the event is dropped. mon_oos clears, but is set if loss of lock occurs on that same edge.
- mon_clear does not alter state or exp_idx.
- Reset mid-operation: immediate return to reset values; no partial update.

Decomposition:
- Shared package/include: state encodings, default pattern constants (IDATA*/QDATA*), counter width (32).
- One sub-module: axi_ad9364_pat_cnt, a 32-bit saturating counter with inc and clr, clr priority. Instantiated twice.

Test Plan:
- Reset then enable, drive valid every other cycle with (3777,3737),(0000,1737),(4000,0000) repeating -> mon_locked=1 one clk after the 4th valid sample; match_count increments from the 5th sample; err_count=0.
- Locked, corrupt one sample to I=12'o3776 -> one mon_err pulse; err_count=1; stay locked; next in-order samples count as matches.
- Locked, corrupt 3 consecutive samples -> err_count=3; mon_locked=0 and mon_oos=1 one clk after the 3rd; relock after 4 good samples; mon_oos stays 1.
- Locked, hold adc_valid=0 for 64 cycles -> SEARCH with mon_oos=1; no counter change.
- Preload err_count to 32'hFFFF_FFFE, inject 3 errors with MISS_LIMIT=15 -> count stops at 32'hFFFF_FFFF; mon_clear coincident with a match -> match_count=0.
- Start the stream at entry 2, then assert adc_status=0 mid-lock and deassert mon_enable -> lock from entry 2; SEARCH with mon_oos=1; then mon_state=0 with counters held.

Source files
------------

// File: rtl/axi_ad9364_pat_mon_pkg.sv
// Shared definitions for the AD9364 receive-side pattern monitor:
// state encodings, default test-sequence values and counter width.
package axi_ad9364_pat_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RSVD   = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 32;

  localparam logic [11:0] PAT_I1 = 12'o3777;
  localparam logic [11:0] PAT_I2 = 12'o0000;
  localparam logic [11:0] PAT_I3 = 12'o4000;
  localparam logic [11:0] PAT_Q1 = 12'o3737;
  localparam logic [11:0] PAT_Q2 = 12'o1737;
  localparam logic [11:0] PAT_Q3 = 12'o0000;

  // Sequence index advance, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/axi_ad9364_pat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module axi_ad9364_pat_cnt
  import axi_ad9364_pat_mon_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/axi_ad9364_pat_mon.sv
// Receive-side monitor for the looped-back 3-entry I/Q test sequence:
// locks onto the sequence, flags loss of sync, counts matches and errors.
module axi_ad9364_pat_mon
  import axi_ad9364_pat_mon_pkg::*;
#(
  parameter logic [11:0] IDATA1     = PAT_I1,
  parameter logic [11:0] IDATA2     = PAT_I2,
  parameter logic [11:0] IDATA3     = PAT_I3,
  parameter logic [11:0] QDATA1     = PAT_Q1,
  parameter logic [11:0] QDATA2     = PAT_Q2,
  parameter logic [11:0] QDATA3     = PAT_Q3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mon_enable,
  input  logic             mon_clear,
  input  logic             adc_valid,
  input  logic [11:0]      adc_data_i1,
  input  logic [11:0]      adc_data_q1,
  input  logic             adc_status,
  output logic             mon_locked,
  output logic             mon_oos,
  output logic             mon_err,
  output logic [1:0]       mon_state,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count
);

  state_t      state, state_nxt;
  logic [1:0]  exp_idx, idx_nxt;
  logic [3:0]  run, run_nxt;
  logic [3:0]  miss, miss_nxt;
  logic [15:0] gap, gap_nxt;
  logic [2:0]  hit;
  logic        exp_hit;
  logic [1:0]  hit_idx;
  logic        err_ev, match_ev, lose;

  assign hit[0] = (adc_data_i1 == IDATA1) && (adc_data_q1 == QDATA1);
  assign hit[1] = (adc_data_i1 == IDATA2) && (adc_data_q1 == QDATA2);
  assign hit[2] = (adc_data_i1 == IDATA3) && (adc_data_q1 == QDATA3);

  always_comb begin
    case (exp_idx)
      2'd0:    exp_hit = hit[0];
      2'd1:    exp_hit = hit[1];
      default: exp_hit = hit[2];
    endcase
    hit_idx = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = exp_idx;
    run_nxt   = run;
    miss_nxt  = miss;
    gap_nxt   = gap;
    err_ev    = 1'b0;
    match_ev  = 1'b0;
    lose      = 1'b0;
    if (!mon_enable) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      run_nxt   = '0;
      miss_nxt  = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SEARCH;
          idx_nxt   = '0;
          run_nxt   = '0;
        end
        ST_SEARCH: begin
          if (!adc_status) begin
            run_nxt = '0;
          end else if (adc_valid) begin
            // An in-order match extends the run; any other entry restarts it at 1.
            if ((run != '0) && exp_hit) begin
              run_nxt = run + 4'd1;
              idx_nxt = next_idx(exp_idx);
            end else if (|hit) begin
              run_nxt = 4'd1;
              idx_nxt = next_idx(hit_idx);
            end else begin
              run_nxt = '0;
            end
            if (run_nxt == 4'(LOCK_COUNT)) begin
              state_nxt = ST_LOCKED;
              run_nxt   = '0;
              miss_nxt  = '0;
              gap_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (!adc_status) begin
            lose = 1'b1;
          end else if (adc_valid) begin
            // Index advances on every sample so a single bit error keeps alignment.
            idx_nxt = next_idx(exp_idx);
            gap_nxt = '0;
            if (exp_hit) begin
              match_ev = 1'b1;
              miss_nxt = '0;
            end else begin
              err_ev   = 1'b1;
              miss_nxt = miss + 4'd1;
              if (miss_nxt == 4'(MISS_LIMIT)) lose = 1'b1;
            end
          end else begin
            gap_nxt = gap + 16'd1;
            if (gap == 16'(TIMEOUT - 1)) lose = 1'b1;
          end
          if (lose) begin
            state_nxt = ST_SEARCH;
            run_nxt   = '0;
            miss_nxt  = '0;
            gap_nxt   = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      exp_idx <= '0;
      run     <= '0;
      miss    <= '0;
      gap     <= '0;
      mon_err <= 1'b0;
      mon_oos <= 1'b0;
    end else begin
      state   <= state_nxt;
      exp_idx <= idx_nxt;
      run     <= run_nxt;
      miss    <= miss_nxt;
      gap     <= gap_nxt;
      mon_err <= err_ev;
      mon_oos <= mon_clear ? lose : (mon_oos | lose);
    end
  end

  assign mon_locked = (state == ST_LOCKED);
  assign mon_state  = state;

  axi_ad9364_pat_cnt u_err_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (err_ev),
    .clr   (mon_clear),
    .count (err_count)
  );

  axi_ad9364_pat_cnt u_match_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (match_ev),
    .clr   (mon_clear),
    .count (match_count)
  );

endmodule
